instruction_sequencer: RTL

Multi-cycle fetch/execute controller for the single-instruction RV32I datapath.
- Owns the program counter and fetches instruction words over a req/ack handshake.
- Presents each word to the datapath with its `pcNext`, and issues a one-cycle commit strobe that gates the datapath's register-file and main-memory writes.
- Retires instructions in order, halts on SYSTEM opcodes and traps on illegal opcodes or fetch timeout.

---
 rtl/instruction_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Multi-cycle fetch/execute controller for the single-
//               instruction RV32I datapath. Owns the PC, fetches words over
//               a req/ack handshake, issues a one-cycle commit strobe and
//               retires in order. Halts on SYSTEM, traps on illegal opcode,
//               fetch timeout or (optionally) misaligned JAL target.
//               Optional feature macro: SEQUENCER_JAL_EN (JAL redirects PC).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] instruction,
    output logic [31:0] pcNext,
    output logic        exec_en,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired_count
);

    localparam logic [2:0]  c_ST_IDLE  = 3'd0;
    localparam logic [2:0]  c_ST_FETCH = 3'd1;
    localparam logic [2:0]  c_ST_EXEC  = 3'd2;
    localparam logic [2:0]  c_ST_HALT  = 3'd3;
    localparam logic [2:0]  c_ST_FAULT = 3'd4;

    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [7:0]  c_TIMEOUT  = 8'(FETCH_TIMEOUT);

    localparam logic [6:0]  c_OP_REG    = 7'b0110011;
    localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_pc_next;
    logic [31:0] r_retired;
    logic [7:0]  r_fetch_wait;

    logic [6:0]  w_opcode;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_target;
    logic        w_op_legal;
    logic        w_op_system;
    logic        w_target_bad;
    logic        w_commit;
    logic        w_timeout;
`ifdef SEQUENCER_JAL_EN
    logic [31:0] w_jal_offset;
`endif

    // Decode the held instruction and work out where the PC goes next
    always_comb begin
        w_opcode     = r_instruction[6:0];
        w_pc_seq     = r_pc + 32'd4;
        w_pc_target  = w_pc_seq;
        w_target_bad = 1'b0;
        w_op_system  = (w_opcode == c_OP_SYSTEM);
        w_op_legal   = (w_opcode inside {c_OP_REG, c_OP_IMM, c_OP_LUI,
                                         c_OP_LOAD, c_OP_STORE, c_OP_JAL});
`ifdef SEQUENCER_JAL_EN
        w_jal_offset = {{11{r_instruction[31]}}, r_instruction[31],
                        r_instruction[19:12], r_instruction[20],
                        r_instruction[30:21], 1'b0};
        if (w_opcode == c_OP_JAL) begin
            w_pc_target  = r_pc + w_jal_offset;
            w_target_bad = (w_pc_target[1:0] != 2'b00);
        end
`endif
        w_commit     = w_op_legal && !w_target_bad;
        // Timeout fires on the FETCH cycle that would bring the count to the limit
        w_timeout    = (({1'b0, r_fetch_wait} + 9'd1) == {1'b0, c_TIMEOUT});
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an ack on the timeout cycle takes priority
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_next = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (fetch_ack)      w_state_next = c_ST_EXEC;
                else if (w_timeout) w_state_next = c_ST_FAULT;
            end
            c_ST_EXEC: begin
                if (w_commit)         w_state_next = c_ST_FETCH;
                else if (w_op_system) w_state_next = c_ST_HALT;
                else                  w_state_next = c_ST_FAULT;
            end
            c_ST_HALT: begin
                if (start) w_state_next = c_ST_FETCH;
            end
            c_ST_FAULT: begin
                w_state_next = c_ST_FAULT;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; commit strobe is suppressed while reset is asserted
    always_comb begin
        fetch_req = (r_state == c_ST_FETCH);
        busy      = (r_state == c_ST_FETCH) || (r_state == c_ST_EXEC);
        halted    = (r_state == c_ST_HALT);
        fault     = (r_state == c_ST_FAULT);
        exec_en   = reset_n && (r_state == c_ST_EXEC) && w_commit;
    end

    // PC, instruction/link latch and retire counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_instruction <= c_NOP;
            r_pc_next     <= RESET_PC + 32'd4;
            r_retired     <= '0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (fetch_ack) begin
                        r_instruction <= fetch_data;
                        r_pc_next     <= w_pc_seq;
                    end
                end
                c_ST_EXEC: begin
                    if (w_commit) begin
                        r_pc      <= w_pc_target;
                        r_retired <= r_retired + 32'd1;
                    end
                end
                c_ST_HALT: begin
                    if (start) r_pc <= w_pc_seq;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Fetch wait counter: zero outside FETCH so every FETCH entry starts fresh
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_wait <= '0;
        end else if ((r_state == c_ST_FETCH) && !fetch_ack) begin
            r_fetch_wait <= r_fetch_wait + 8'd1;
        end else begin
            r_fetch_wait <= '0;
        end
    end

    assign fetch_addr    = r_pc;
    assign pc            = r_pc;
    assign instruction   = r_instruction;
    assign pcNext        = r_pc_next;
    assign retired_count = r_retired;

endmodule
`default_nettype wire
